// File: rtl/gpu_arb_pkg.sv
// Shared types and constants for the GPU pixel arbiter slice.
// Optional revocation timer is enabled by defining GPU_ARB_TIMEOUT_EN.
`ifndef WIDTH_BITS
`define WIDTH_BITS 12
`endif
`ifndef HEIGHT_BITS
`define HEIGHT_BITS 12
`endif

package gpu_arb_pkg;

    localparam int GPU_NUM_REQ = 4;
    localparam int REQ_ID_W    = $clog2(GPU_NUM_REQ);

    typedef logic [REQ_ID_W-1:0] req_id_t;

    localparam req_id_t REQ_LINE   = req_id_t'(0);
    localparam req_id_t REQ_FILL   = req_id_t'(1);
    localparam req_id_t REQ_ARC    = req_id_t'(2);
    localparam req_id_t REQ_CIRCLE = req_id_t'(3);

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // Observation bundle: FSM state plus the two arbitration registers.
    typedef struct packed {
        arb_state_t state;
        req_id_t    grant;
        req_id_t    rr_ptr;
    } arb_dbg_t;

    function automatic int next_index(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/gpu_pixel_arbiter_if.sv
// Pixel bus between the rasterizers, the arbiter and the frame-buffer writer.
// Handshake: a pixel moves on any rising edge where its valid and ready are both 1;
// the producer holds valid and payload stable until then, ready may depend on valid.
`ifndef WIDTH_BITS
`define WIDTH_BITS 12
`endif
`ifndef HEIGHT_BITS
`define HEIGHT_BITS 12
`endif

interface gpu_pixel_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]                   req_valid_i;
    logic [NUM_REQ-1:0]                   req_last_i;
    logic [NUM_REQ-1:0][`WIDTH_BITS-1:0]  req_x_i;
    logic [NUM_REQ-1:0][`HEIGHT_BITS-1:0] req_y_i;
    logic [NUM_REQ-1:0]                   req_ready_o;

    logic [`WIDTH_BITS-1:0]               x_o;
    logic [`HEIGHT_BITS-1:0]              y_o;
    logic [ID_W-1:0]                      src_o;
    logic                                 valid_o;
    logic                                 ready_i;

    modport master (
        output req_valid_i, req_last_i, req_x_i, req_y_i, ready_i,
        input  req_ready_o, x_o, y_o, src_o, valid_o
    );

    modport slave (
        input  req_valid_i, req_last_i, req_x_i, req_y_i, ready_i,
        output req_ready_o, x_o, y_o, src_o, valid_o
    );

endinterface

// File: rtl/gpu_rr_picker.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr, wrapping.
module gpu_rr_picker
    import gpu_arb_pkg::*;
#(
    parameter  int NUM_REQ = GPU_NUM_REQ,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [ID_W-1:0]    pick,
    output logic               any_valid
);

    always_comb begin
        int idx;
        idx       = 0;
        pick      = '0;
        any_valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!any_valid && valid[idx]) begin
                pick      = ID_W'(idx);
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpu_pixel_arbiter.sv
// Shares one registered pixel output among the line/fill/arc/circle rasterizers.
// Define GPU_ARB_TIMEOUT_EN to revoke grants whose owner goes quiet for TIMEOUT_CYCLES.
module gpu_pixel_arbiter
    import gpu_arb_pkg::*;
#(
    parameter int NUM_REQ        = GPU_NUM_REQ,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    gpu_pixel_arbiter_if.slave    bus,
    output logic                  busy_o,
    output logic                  timeout_o,
    output arb_dbg_t              dbg_o
);

    localparam int ID_W = $clog2(NUM_REQ);

    arb_state_t              state_q;
    logic [ID_W-1:0]         grant_q;
    logic [ID_W-1:0]         rr_ptr_q;
    logic [ID_W-1:0]         pick;
    logic                    any_valid;

    logic                    valid_q;
    logic [`WIDTH_BITS-1:0]  x_q;
    logic [`HEIGHT_BITS-1:0] y_q;
    logic [ID_W-1:0]         src_q;

    logic                    slot_free;
    logic                    xfer;
    logic                    xfer_last;
    logic                    revoke;
    logic [NUM_REQ-1:0]      req_ready;
    logic [ID_W-1:0]         next_ptr;

    gpu_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .valid     (bus.req_valid_i),
        .rr_ptr    (rr_ptr_q),
        .pick      (pick),
        .any_valid (any_valid)
    );

    // The output slot can take a new pixel when empty or draining this cycle.
    always_comb begin
        slot_free = !valid_q || bus.ready_i;
        req_ready = '0;
        if (state_q == ARB_LOCKED && !rst) begin
            req_ready[grant_q] = slot_free;
        end
        xfer      = (state_q == ARB_LOCKED) && bus.req_valid_i[grant_q] && slot_free;
        xfer_last = xfer && bus.req_last_i[grant_q];
        next_ptr  = ID_W'(next_index(int'(grant_q), NUM_REQ));
    end

`ifdef GPU_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TW-1:0] timer_q;
    logic          timeout_q;

    assign revoke = (state_q == ARB_LOCKED) && !bus.req_valid_i[grant_q] &&
                    (timer_q == TW'(TIMEOUT_CYCLES - 1));

    // Counts only cycles where the owner presents nothing; a stalled pixel is not idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= revoke;
            if (state_q != ARB_LOCKED || xfer || revoke) begin
                timer_q <= '0;
            end else if (!bus.req_valid_i[grant_q]) begin
                timer_q <= timer_q + TW'(1);
            end
        end
    end

    assign timeout_o = timeout_q;
`else
    assign revoke    = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            valid_q  <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            src_q    <= '0;
        end else begin
            if (xfer) begin
                x_q     <= bus.req_x_i[grant_q];
                y_q     <= bus.req_y_i[grant_q];
                src_q   <= grant_q;
                valid_q <= 1'b1;
            end else if (bus.ready_i) begin
                valid_q <= 1'b0;
            end

            unique case (state_q)
                ARB_IDLE: begin
                    if (any_valid) begin
                        grant_q <= pick;
                        state_q <= ARB_LOCKED;
                    end
                end
                ARB_LOCKED: begin
                    if (xfer_last || revoke) begin
                        state_q  <= ARB_IDLE;
                        rr_ptr_q <= next_ptr;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    assign bus.req_ready_o = req_ready;
    assign bus.x_o         = x_q;
    assign bus.y_o         = y_q;
    assign bus.src_o       = src_q;
    assign bus.valid_o     = valid_q;

    assign busy_o       = (state_q == ARB_LOCKED) || valid_q;
    assign dbg_o.state  = state_q;
    assign dbg_o.grant  = req_id_t'(grant_q);
    assign dbg_o.rr_ptr = req_id_t'(rr_ptr_q);

endmodule
